// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-client command sequencer for a single-port RAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed port-0 priority (default: round-robin).
module ram_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDCAP  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic we_q, we_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic busy_q, busy_d;
  logic ram_we_q, ram_we_d, ram_re_q, ram_re_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic win1;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Port 0 takes every tie.
  always_comb win1 = req1 & ~req0;
`else
  logic ptr_q, ptr_d;

  // On a tie the port not granted last wins.
  always_comb win1 = req1 & (~req0 | ~ptr_q);

  // Last-granted pointer; port 1 after reset so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    ram_we_d  = 1'b0;
    ram_re_d  = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d  = win1;
          we_d     = win1 ? we1 : we0;
          addr_d   = win1 ? addr1 : addr0;
          wdata_d  = win1 ? wdata1 : wdata0;
          gnt0_d   = ~win1;
          gnt1_d   = win1;
          ram_we_d = we_d;
          ram_re_d = ~we_d;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
`ifndef RAM_ARB_FIXED_PRIO_EN
        ptr_d = owner_q;
`endif
        if (we_q) begin
          state_d = IDLE;
        end else begin
          ram_re_d = 1'b1;
          state_d  = RDCAP;
        end
      end
      RDCAP: begin
        state_d = IDLE;
        if (owner_q) begin
          rdata1_d  = ram_rdata;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = ram_rdata;
          rvalid0_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      busy_q    <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_re_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      busy_q    <= busy_d;
      ram_we_q  <= ram_we_d;
      ram_re_q  <= ram_re_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule
